// File: rtl/pixel_frame_writer.sv
// Subsampling framebuffer writer: qualifies the shaded pixel stream, writes a ping-pong BRAM,
// and swaps banks on vsync. Define PIXEL_CHECKSUM_EN to add a per-frame write checksum.
module pixel_frame_writer #(
   parameter int unsigned H_RES  = 1280,
   parameter int unsigned V_RES  = 720,
   parameter int unsigned DS     = 4,
   parameter int unsigned ADDR_W = 16,
   parameter logic [11:0] BG_RGB = 12'h000
) (
   input  logic              clk_in,
   input  logic              rst_in_n,
   input  logic [10:0]       x_in,
   input  logic [9:0]        y_in,
   input  logic [3:0]        r_in,
   input  logic [3:0]        g_in,
   input  logic [3:0]        b_in,
   input  logic              block_visible_in,
   input  logic              rgb_valid_in,
   input  logic              vsync_in,
   output logic              fb_wr_en,
   output logic              fb_wr_bank,
   output logic [ADDR_W-1:0] fb_wr_addr,
   output logic [11:0]       fb_wr_data,
   output logic              disp_bank_out,
   output logic              render_start_out,
   output logic              frame_done_out,
   output logic [15:0]       dropped_count_out,
   output logic [15:0]       frame_checksum_out
);

   localparam int unsigned DS_SH = $clog2(DS);
   localparam int unsigned COLS  = H_RES / DS;

   localparam logic [10:0] H_RES_X = 11'(H_RES);
   localparam logic [9:0]  V_RES_Y = 10'(V_RES);
   localparam logic [10:0] X_LAST  = 11'(H_RES - 1);
   localparam logic [9:0]  Y_LAST  = 10'(V_RES - 1);
   localparam logic [10:0] X_MASK  = 11'(DS - 1);
   localparam logic [9:0]  Y_MASK  = 10'(DS - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RENDER    = 2'd1,
      S_WAIT_SWAP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              draw_bank_q, draw_bank_d;
   logic              disp_bank_q, disp_bank_d;
   logic              swap_pending_q, swap_pending_d;
   logic              vsync_q;
   logic              render_start_q, render_start_d;
   logic              frame_done_q, frame_done_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;

   logic              s1_valid_q, s1_valid_d;
   logic [10:0]       s1_x_q, s1_x_d;
   logic [9:0]        s1_y_q, s1_y_d;
   logic [11:0]       s1_data_q, s1_data_d;
   logic              s1_bank_q, s1_bank_d;

   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [11:0]       wr_data_q, wr_data_d;
   logic              wr_bank_q, wr_bank_d;

   logic              in_range_c;
   logic              on_grid_c;
   logic              is_last_c;
   logic              vsync_rise_c;
   logic              pipe_empty_c;
   logic              drop_c;

   assign in_range_c   = (x_in < H_RES_X) && (y_in < V_RES_Y);
   assign on_grid_c    = ((x_in & X_MASK) == 11'd0) && ((y_in & Y_MASK) == 10'd0);
   assign is_last_c    = (x_in == X_LAST) && (y_in == Y_LAST);
   assign vsync_rise_c = vsync_in & ~vsync_q;
   assign pipe_empty_c = ~s1_valid_q & ~wr_en_q;

   // Frame sequencing, pixel qualification (stage 1) and address formation (stage 2)
   always_comb begin
      state_d        = state_q;
      draw_bank_d    = draw_bank_q;
      disp_bank_d    = disp_bank_q;
      swap_pending_d = swap_pending_q;
      render_start_d = 1'b0;
      frame_done_d   = 1'b0;
      drop_c         = 1'b0;
      s1_valid_d     = 1'b0;
      s1_x_d         = 11'(x_in >> DS_SH);
      s1_y_d         = 10'(y_in >> DS_SH);
      s1_data_d      = block_visible_in ? {r_in, g_in, b_in} : BG_RGB;
      s1_bank_d      = draw_bank_q;

      unique case (state_q)
         S_IDLE: begin
            render_start_d = 1'b1;
            state_d        = S_RENDER;
         end
         S_RENDER: begin
            if (rgb_valid_in) begin
               if (!in_range_c) begin
                  drop_c = 1'b1;
               end else begin
                  s1_valid_d = on_grid_c;
                  if (is_last_c) begin
                     frame_done_d = 1'b1;
                     state_d      = S_WAIT_SWAP;
                  end
               end
            end
         end
         S_WAIT_SWAP: begin
            drop_c = rgb_valid_in;
            if (vsync_rise_c) begin
               swap_pending_d = 1'b1;
            end
            // Bank flips only once the last in-flight write has left the pipeline
            if (swap_pending_q && pipe_empty_c) begin
               disp_bank_d    = ~disp_bank_q;
               draw_bank_d    = disp_bank_q;
               render_start_d = 1'b1;
               swap_pending_d = 1'b0;
               state_d        = S_RENDER;
            end
         end
         default: state_d = S_IDLE;
      endcase

      drop_cnt_d = (drop_c && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;

      wr_en_d   = s1_valid_q;
      wr_addr_d = ADDR_W'(s1_y_q) * ADDR_W'(COLS) + ADDR_W'(s1_x_q);
      wr_data_d = s1_data_q;
      wr_bank_d = s1_bank_q;
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_q        <= S_IDLE;
         draw_bank_q    <= 1'b1;
         disp_bank_q    <= 1'b0;
         swap_pending_q <= 1'b0;
         vsync_q        <= 1'b0;
         render_start_q <= 1'b0;
         frame_done_q   <= 1'b0;
         drop_cnt_q     <= 16'h0000;
         s1_valid_q     <= 1'b0;
         s1_x_q         <= 11'd0;
         s1_y_q         <= 10'd0;
         s1_data_q      <= 12'h000;
         s1_bank_q      <= 1'b0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= 12'h000;
         wr_bank_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         draw_bank_q    <= draw_bank_d;
         disp_bank_q    <= disp_bank_d;
         swap_pending_q <= swap_pending_d;
         vsync_q        <= vsync_in;
         render_start_q <= render_start_d;
         frame_done_q   <= frame_done_d;
         drop_cnt_q     <= drop_cnt_d;
         s1_valid_q     <= s1_valid_d;
         s1_x_q         <= s1_x_d;
         s1_y_q         <= s1_y_d;
         s1_data_q      <= s1_data_d;
         s1_bank_q      <= s1_bank_d;
         wr_en_q        <= wr_en_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         wr_bank_q      <= wr_bank_d;
      end
   end

`ifdef PIXEL_CHECKSUM_EN
   logic [15:0] acc_q;
   logic [15:0] acc_next_c;
   logic [15:0] csum_q;

   // Address 0 opens a new frame, so the running sum restarts from that pixel
   always_comb begin
      acc_next_c = acc_q;
      if (wr_en_q) begin
         acc_next_c = (wr_addr_q == '0) ? 16'(wr_data_q) : acc_q + 16'(wr_data_q);
      end
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         acc_q  <= 16'h0000;
         csum_q <= 16'h0000;
      end else begin
         acc_q <= acc_next_c;
         if (frame_done_q) begin
            csum_q <= acc_next_c;
         end
      end
   end

   assign frame_checksum_out = csum_q;
`else
   assign frame_checksum_out = 16'h0000;
`endif

   assign fb_wr_en          = wr_en_q;
   assign fb_wr_bank        = wr_bank_q;
   assign fb_wr_addr        = wr_addr_q;
   assign fb_wr_data        = wr_data_q;
   assign disp_bank_out     = disp_bank_q;
   assign render_start_out  = render_start_q;
   assign frame_done_out    = frame_done_q;
   assign dropped_count_out = drop_cnt_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer: vector table for single pixels plus hand sequences
// for frame end, vsync swap, mid-frame reset and drop-counter saturation.
module tb_pixel_frame_writer;

   logic        clk_in;
   logic        rst_in_n;
   logic [10:0] x_in;
   logic [9:0]  y_in;
   logic [3:0]  r_in;
   logic [3:0]  g_in;
   logic [3:0]  b_in;
   logic        block_visible_in;
   logic        rgb_valid_in;
   logic        vsync_in;
   logic        fb_wr_en;
   logic        fb_wr_bank;
   logic [15:0] fb_wr_addr;
   logic [11:0] fb_wr_data;
   logic        disp_bank_out;
   logic        render_start_out;
   logic        frame_done_out;
   logic [15:0] dropped_count_out;
   logic [15:0] frame_checksum_out;

`ifdef PIXEL_CHECKSUM_EN
   localparam logic [15:0] EXP_CSUM = 16'h0F90;
`else
   localparam logic [15:0] EXP_CSUM = 16'h0000;
`endif

   pixel_frame_writer dut (
      .clk_in             (clk_in),
      .rst_in_n           (rst_in_n),
      .x_in               (x_in),
      .y_in               (y_in),
      .r_in               (r_in),
      .g_in               (g_in),
      .b_in               (b_in),
      .block_visible_in   (block_visible_in),
      .rgb_valid_in       (rgb_valid_in),
      .vsync_in           (vsync_in),
      .fb_wr_en           (fb_wr_en),
      .fb_wr_bank         (fb_wr_bank),
      .fb_wr_addr         (fb_wr_addr),
      .fb_wr_data         (fb_wr_data),
      .disp_bank_out      (disp_bank_out),
      .render_start_out   (render_start_out),
      .frame_done_out     (frame_done_out),
      .dropped_count_out  (dropped_count_out),
      .frame_checksum_out (frame_checksum_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic [3:0]  r;
      logic [3:0]  g;
      logic [3:0]  b;
      logic        vis;
      logic        exp_wr;
      logic [15:0] exp_addr;
      logic [11:0] exp_data;
      logic [15:0] exp_drop;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one pixel for one cycle; returns at the negedge after capture
   task automatic send_pixel(input logic [10:0] x, input logic [9:0] y, input logic [3:0] r,
                             input logic [3:0] g, input logic [3:0] b, input logic vis);
      x_in = x; y_in = y; r_in = r; g_in = g; b_in = b;
      block_visible_in = vis;
      rgb_valid_in     = 1'b1;
      @(negedge clk_in);
      rgb_valid_in = 1'b0;
   endtask

   task automatic wait_start(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk_in);
         if (render_start_out) ok = 1'b1;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic ok;
      int   hits;

      vecs[0] = '{11'd8,    10'd4,   4'hF, 4'h8, 4'h1, 1'b1, 1'b1, 16'd322,   12'hF81, 16'd0};
      vecs[1] = '{11'd9,    10'd4,   4'hF, 4'h8, 4'h1, 1'b1, 1'b0, 16'd0,     12'h000, 16'd0};
      vecs[2] = '{11'd0,    10'd0,   4'h5, 4'h5, 4'h5, 1'b0, 1'b1, 16'd0,     12'h000, 16'd0};
      vecs[3] = '{11'd1300, 10'd4,   4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 16'd0,     12'h000, 16'd1};
      vecs[4] = '{11'd1276, 10'd716, 4'hA, 4'hB, 4'hC, 1'b1, 1'b1, 16'd57599, 12'hABC, 16'd1};
      vecs[5] = '{11'd0,    10'd720, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 16'd0,     12'h000, 16'd2};
      vecs[6] = '{11'd12,   10'd8,   4'h1, 4'h2, 4'h3, 1'b1, 1'b1, 16'd643,   12'h123, 16'd2};

      rst_in_n = 1'b0;
      x_in = '0; y_in = '0; r_in = '0; g_in = '0; b_in = '0;
      block_visible_in = 1'b0; rgb_valid_in = 1'b0; vsync_in = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_wr_en", fb_wr_en, 0);
      chk("rst_disp_bank", disp_bank_out, 0);
      chk("rst_render_start", render_start_out, 0);
      chk("rst_dropped", dropped_count_out, 0);
      chk("rst_checksum", frame_checksum_out, 0);

      rst_in_n = 1'b1;
      @(negedge clk_in);
      chk("start_pulse", render_start_out, 1);
      chk("start_disp_bank", disp_bank_out, 0);
      @(negedge clk_in);
      chk("start_pulse_end", render_start_out, 0);

      // Frame 1: single-pixel vectors, draw bank 1
      for (int i = 0; i < 7; i++) begin
         send_pixel(vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].vis);
         chk($sformatf("v%0d_stage1_idle", i), fb_wr_en, 0);
         @(negedge clk_in);
         chk($sformatf("v%0d_wr_en", i), fb_wr_en, vecs[i].exp_wr);
         if (vecs[i].exp_wr) begin
            chk($sformatf("v%0d_addr", i), fb_wr_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_data", i), fb_wr_data, vecs[i].exp_data);
            chk($sformatf("v%0d_bank", i), fb_wr_bank, 1);
         end
         chk($sformatf("v%0d_dropped", i), dropped_count_out, vecs[i].exp_drop);
      end

      // End of frame 1, then a pixel during WAIT_SWAP
      send_pixel(11'd1279, 10'd719, 4'h1, 4'h1, 4'h1, 1'b1);
      chk("f1_done", frame_done_out, 1);
      send_pixel(11'd0, 10'd0, 4'hF, 4'hF, 4'hF, 1'b1);
      chk("f1_done_end", frame_done_out, 0);
      chk("wait_drop", dropped_count_out, 3);
      @(negedge clk_in);
      chk("wait_no_wr_a", fb_wr_en, 0);
      @(negedge clk_in);
      chk("wait_no_wr_b", fb_wr_en, 0);

      vsync_in = 1'b1;
      wait_start(ok);
      chk("swap1_start", ok, 1);
      chk("swap1_disp_bank", disp_bank_out, 1);
      vsync_in = 1'b0;
      @(negedge clk_in);
      chk("swap1_start_end", render_start_out, 0);

      // Frame 2 in bank 0
      send_pixel(11'd0, 10'd0, 4'hF, 4'h8, 4'h1, 1'b1);
      @(negedge clk_in);
      chk("f2_p0_wr", fb_wr_en, 1);
      chk("f2_p0_addr", fb_wr_addr, 0);
      chk("f2_p0_data", fb_wr_data, 12'hF81);
      chk("f2_p0_bank", fb_wr_bank, 0);
      send_pixel(11'd4, 10'd0, 4'h0, 4'h0, 4'hF, 1'b1);
      @(negedge clk_in);
      chk("f2_p1_wr", fb_wr_en, 1);
      chk("f2_p1_addr", fb_wr_addr, 1);
      chk("f2_p1_data", fb_wr_data, 12'h00F);
      chk("f2_p1_bank", fb_wr_bank, 0);

      // Last pixel coincident with vsync rise: that edge must not swap
      vsync_in = 1'b1;
      send_pixel(11'd1279, 10'd719, 4'h1, 4'h1, 4'h1, 1'b1);
      chk("f2_done", frame_done_out, 1);
      @(negedge clk_in);
      chk("f2_checksum", frame_checksum_out, EXP_CSUM);
      hits = 0;
      repeat (6) begin
         @(negedge clk_in);
         if (render_start_out) hits++;
      end
      chk("early_edge_no_start", hits, 0);
      chk("early_edge_disp_bank", disp_bank_out, 1);
      vsync_in = 1'b0;
      @(negedge clk_in);
      vsync_in = 1'b1;
      wait_start(ok);
      chk("swap2_start", ok, 1);
      chk("swap2_disp_bank", disp_bank_out, 0);
      vsync_in = 1'b0;

      // Frame 3: out-of-range drop, then a write back in bank 1
      send_pixel(11'd1300, 10'd4, 4'h1, 4'h1, 4'h1, 1'b1);
      chk("f3_drop", dropped_count_out, 4);
      @(negedge clk_in);
      chk("f3_drop_no_wr", fb_wr_en, 0);
      send_pixel(11'd8, 10'd4, 4'hF, 4'h8, 4'h1, 1'b1);
      @(negedge clk_in);
      chk("f3_wr", fb_wr_en, 1);
      chk("f3_addr", fb_wr_addr, 322);
      chk("f3_bank", fb_wr_bank, 1);

      // Reset while a write sits in stage 1
      send_pixel(11'd8, 10'd4, 4'hF, 4'h8, 4'h1, 1'b1);
      rst_in_n = 1'b0;
      #1;
      chk("midrst_wr_en", fb_wr_en, 0);
      chk("midrst_dropped", dropped_count_out, 0);
      chk("midrst_disp_bank", disp_bank_out, 0);
      chk("midrst_frame_done", frame_done_out, 0);
      @(negedge clk_in);
      rst_in_n = 1'b1;
      @(negedge clk_in);
      chk("midrst_start", render_start_out, 1);
      hits = fb_wr_en ? 1 : 0;
      repeat (3) begin
         @(negedge clk_in);
         if (fb_wr_en) hits++;
      end
      chk("midrst_no_wr", hits, 0);

      // Drop counter counts then saturates
      x_in = 11'd1300; y_in = 10'd4;
      rgb_valid_in = 1'b1;
      repeat (100) @(negedge clk_in);
      chk("drop_count_100", dropped_count_out, 100);
      repeat (65440) @(negedge clk_in);
      rgb_valid_in = 1'b0;
      @(negedge clk_in);
      chk("drop_saturate", dropped_count_out, 16'hFFFF);
      chk("drop_sat_no_wr", fb_wr_en, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
